rv32i_mem_pipe: RTL

Memory-access stage of the rv32i pipeline, placed directly downstream of the ALU stage. It consumes the ALU stage's data_ready/stall/execute handshake and drives that stage's downstream stall/execute inputs. It also runs a single-outstanding req/ack bus transaction for loads and stores, and passes non-memory results through with one cycle of latency toward writeback.

---
 rtl/rv32i_mem_pipe.sv | 110 +++++++++++
 1 files changed

// File: rtl/rv32i_mem_pipe.sv
// rv32i_mem_pipe: rv32i memory-access stage with a single-outstanding req/ack bus and one-cycle pass-through.
// Define RV32I_MEM_MISALIGN_EN to trap misaligned H/W accesses instead of forcing them aligned.
module rv32i_mem_pipe #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            clear_i,
    input  logic            data_ready_i,
    input  logic [XLEN-1:0] result_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [2:0]      mem_funct3_i,
    output logic            stall_o,
    output logic            execute_o,
    output logic            data_ready_o,
    output logic [XLEN-1:0] data_o,
    input  logic            downstream_stall_i,
    input  logic            downstream_execute_i,
    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [XLEN-1:0] bus_addr_o,
    output logic [31:0]     bus_wdata_o,
    output logic [3:0]      bus_be_o,
    input  logic            bus_ack_i,
    input  logic [31:0]     bus_rdata_i,
    output logic            misaligned_o
);
    localparam logic IDLE = 1'b0;
    localparam logic WAIT = 1'b1;

    logic            state, occupied, discard, we_q, busy, is_mem, mis;
    logic [XLEN-1:0] addr_q;
    logic [2:0]      f3_q;
    logic [31:0]     sdata_q, load_data;
    logic [7:0]      lb;
    logic [15:0]     lh;

    assign busy         = state == WAIT;
    assign is_mem       = mem_read_i | mem_write_i;
    assign stall_o      = (occupied & downstream_stall_i) | busy;
    assign execute_o    = data_ready_i & ~stall_o;
    assign data_ready_o = occupied & ~busy & ~discard;

`ifdef RV32I_MEM_MISALIGN_EN
    assign mis = (mem_funct3_i[1:0] == 2'b01 && result_i[0]) ||
                 (mem_funct3_i[1:0] == 2'b10 && result_i[1:0] != 2'b00);
    always_ff @(posedge clk_i or negedge reset_ni)
        if (!reset_ni) misaligned_o <= 1'b0;
        else misaligned_o <= execute_o && !clear_i && is_mem && mis;
`else
    assign mis          = 1'b0;
    assign misaligned_o = 1'b0;
`endif

    always_comb begin
        lb        = addr_q[1] ? (addr_q[0] ? bus_rdata_i[31:24] : bus_rdata_i[23:16])
                              : (addr_q[0] ? bus_rdata_i[15:8] : bus_rdata_i[7:0]);
        lh        = addr_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        load_data = f3_q[1] ? bus_rdata_i :
                    f3_q[0] ? {{16{~f3_q[2] & lh[15]}}, lh} : {{24{~f3_q[2] & lb[7]}}, lb};
    end

    // Bus outputs come purely from latched fields, so they hold steady for the whole WAIT.
    always_comb begin
        bus_req_o   = busy;
        bus_we_o    = busy & we_q;
        bus_addr_o  = busy ? {addr_q[XLEN-1:2], 2'b00} : '0;
        bus_wdata_o = !(busy && we_q) ? 32'h0 :
                      f3_q[1] ? sdata_q : f3_q[0] ? {2{sdata_q[15:0]}} : {4{sdata_q[7:0]}};
        bus_be_o    = !busy ? 4'b0000 :
                      (!we_q || f3_q[1]) ? 4'b1111 :
                      f3_q[0] ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b0001 << addr_q[1:0];
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state    <= IDLE;
            occupied <= 1'b0;
            discard  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            f3_q     <= 3'b000;
            sdata_q  <= 32'h0;
            data_o   <= '0;
        end else begin
            occupied <= clear_i ? 1'b0 : execute_o ? 1'b1 : downstream_execute_i ? 1'b0 : occupied;
            if (busy) begin
                if (clear_i) discard <= 1'b1;
                // A flushed transaction still runs to its ack but leaves data_o untouched.
                if (bus_ack_i) begin
                    state   <= IDLE;
                    discard <= 1'b0;
                    if (!discard && !clear_i) data_o <= we_q ? '0 : load_data;
                end
            end else if (execute_o && !clear_i) begin
                if (is_mem && !mis) begin
                    state   <= WAIT;
                    addr_q  <= result_i;
                    f3_q    <= mem_funct3_i;
                    we_q    <= mem_write_i & ~mem_read_i;
                    sdata_q <= store_data_i;
                end else begin
                    data_o <= mis ? '0 : result_i;
                end
            end
        end
    end
endmodule
